// File: rtl/alu_seq_pkg.sv
// Shared definitions for the registered ALU: op encoding (unchanged from the
// 4-bit combinational ALU) and the control FSM states.
package alu_seq_pkg;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_XOR = 3'd3;
    localparam logic [2:0] OP_OR  = 3'd4;
    localparam logic [2:0] OP_ROL = 3'd5;
    localparam logic [2:0] OP_ROR = 3'd6;
    localparam logic [2:0] OP_MUL = 3'd7;

    typedef enum logic {
        IDLE = 1'b0,
        MUL  = 1'b1
    } state_e;

endpackage

// File: rtl/alu_seq_mul.sv
// Shift-add multiplier: loads on start, performs one step per clock and
// flags done combinationally on the W-th step so the product lands that edge.
module alu_seq_mul
    import alu_seq_pkg::*;
#(
    parameter int unsigned W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [W-1:0]     a,
    input  logic [W-1:0]     b,
    output logic             done,
    output logic [2*W-1:0]   product
);

    localparam int unsigned CW = $clog2(W);

    logic [2*W-1:0] mcand;
    logic [2*W-1:0] acc;
    logic [2*W-1:0] acc_nx;
    logic [W-1:0]   mplier;
    logic [CW-1:0]  cnt;
    logic           busy;

    always_comb begin
        acc_nx = acc;
        if (mplier[0]) begin
            acc_nx = acc + mcand;
        end
    end

    // Product is the accumulator including the current step, valid with done.
    assign done    = busy && (cnt == CW'(W - 1));
    assign product = acc_nx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            cnt    <= '0;
            busy   <= 1'b0;
        end else if (start) begin
            mcand  <= {{W{1'b0}}, a};
            mplier <= b;
            acc    <= '0;
            cnt    <= '0;
            busy   <= 1'b1;
        end else if (busy) begin
            acc    <= acc_nx;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + 1'b1;
            if (cnt == CW'(W - 1)) begin
                busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_seq.sv
// Registered ALU with valid/ready handshakes: single-cycle ops register on the
// accept edge, multiply runs W cycles through the shift-add sub-module.
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter  int unsigned W  = 4,
    localparam int unsigned OW = 2 * W + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [W-1:0]  in1,
    input  logic [W-1:0]  in2,
    input  logic [2:0]    op,
    input  logic          in_valid,
    output logic          in_ready,
    output logic [OW-1:0] out,
    output logic          zero,
    output logic          carry,
    output logic          out_valid,
    input  logic          out_ready
);

    localparam int unsigned CW = $clog2(W);

    state_e          state;
    state_e          state_nx;
    logic            accept;
    logic            mul_start;
    logic            mul_done;
    logic [2*W-1:0]  product;
    logic [W:0]      addv;
    logic [W:0]      subv;
    logic [W-1:0]    rolv;
    logic [W-1:0]    rorv;
    logic [CW-1:0]   amt;
    logic [OW-1:0]   res;

    assign in_ready  = (state == IDLE) && (!out_valid || out_ready);
    assign accept    = in_valid && in_ready;
    assign mul_start = accept && (op == OP_MUL);

    alu_seq_mul #(.W(W)) u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (mul_start),
        .a       (in1),
        .b       (in2),
        .done    (mul_done),
        .product (product)
    );

    always_comb begin
        addv = {1'b0, in1} + {1'b0, in2};
        subv = {1'b0, in1} - {1'b0, in2};
        amt  = in2[CW-1:0];
        // W is a power of two, so CW-bit index arithmetic wraps modulo W.
        for (int unsigned i = 0; i < W; i++) begin
            rolv[i] = in1[CW'(i) - amt];
            rorv[i] = in1[CW'(i) + amt];
        end
        case (op)
            OP_ADD:  res = OW'(addv);
            OP_SUB:  res = OW'(subv);
            OP_AND:  res = OW'(in1 & in2);
            OP_XOR:  res = OW'(in1 ^ in2);
            OP_OR:   res = OW'(in1 | in2);
            OP_ROL:  res = OW'(rolv);
            OP_ROR:  res = OW'(rorv);
            default: res = '0;
        endcase
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (mul_start) state_nx = MUL;
            MUL:     if (mul_done)  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out       <= '0;
            zero      <= 1'b0;
            carry     <= 1'b0;
            out_valid <= 1'b0;
        end else if ((state == MUL) && mul_done) begin
            out       <= {1'b0, product};
            zero      <= (product == '0);
            carry     <= 1'b0;
            out_valid <= 1'b1;
        end else if (accept && (op != OP_MUL)) begin
            out       <= res;
            zero      <= (res == '0);
            carry     <= ((op == OP_ADD) || (op == OP_SUB)) ? res[W] : 1'b0;
            out_valid <= 1'b1;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Directed self-checking bench for alu_seq at W=4.
module tb_alu_seq;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] in1;
    logic [3:0] in2;
    logic [2:0] op;
    logic       in_valid;
    logic       in_ready;
    logic [8:0] out;
    logic       zero;
    logic       carry;
    logic       out_valid;
    logic       out_ready;

    int n_checks = 0;
    int n_fail   = 0;

    alu_seq #(.W(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in1       (in1),
        .in2       (in2),
        .op        (op),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out       (out),
        .zero      (zero),
        .carry     (carry),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    task automatic issue(input logic [3:0] a, input logic [3:0] b, input logic [2:0] o);
        @(negedge clk);
        in1 = a; in2 = b; op = o; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic test_reset;
        #2;
        n_checks++; if (out !== 9'h000) begin n_fail++; $display("FAIL reset_out: got %h expected %h", out, 9'h000); end
        n_checks++; if (zero !== 1'b0) begin n_fail++; $display("FAIL reset_zero: got %b expected 0", zero); end
        n_checks++; if (carry !== 1'b0) begin n_fail++; $display("FAIL reset_carry: got %b expected 0", carry); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    endtask

    task automatic test_add;
        issue(4'd15, 4'd1, 3'd0);
        n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL add_valid: got %b expected 1", out_valid); end
        n_checks++; if (out !== 9'h010) begin n_fail++; $display("FAIL add_out: got %h expected %h", out, 9'h010); end
        n_checks++; if (carry !== 1'b1) begin n_fail++; $display("FAIL add_carry: got %b expected 1", carry); end
        n_checks++; if (zero !== 1'b0) begin n_fail++; $display("FAIL add_zero: got %b expected 0", zero); end
        @(posedge clk);
        #1;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL add_consumed: got %b expected 0", out_valid); end
    endtask

    task automatic test_sub;
        issue(4'd3, 4'd5, 3'd1);
        n_checks++; if (out !== 9'h01E) begin n_fail++; $display("FAIL sub_borrow_out: got %h expected %h", out, 9'h01E); end
        n_checks++; if (carry !== 1'b1) begin n_fail++; $display("FAIL sub_borrow_carry: got %b expected 1", carry); end
        n_checks++; if (zero !== 1'b0) begin n_fail++; $display("FAIL sub_borrow_zero: got %b expected 0", zero); end
        issue(4'd5, 4'd5, 3'd1);
        n_checks++; if (out !== 9'h000) begin n_fail++; $display("FAIL sub_equal_out: got %h expected %h", out, 9'h000); end
        n_checks++; if (zero !== 1'b1) begin n_fail++; $display("FAIL sub_equal_zero: got %b expected 1", zero); end
        n_checks++; if (carry !== 1'b0) begin n_fail++; $display("FAIL sub_equal_carry: got %b expected 0", carry); end
        n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL sub_equal_valid: got %b expected 1", out_valid); end
    endtask

    task automatic test_mul;
        issue(4'd15, 4'd15, 3'd7);
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL mul_ready_c1: got %b expected 0", in_ready); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mul_valid_c1: got %b expected 0", out_valid); end
        for (int k = 2; k <= 4; k++) begin
            @(posedge clk);
            #1;
            n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL mul_ready_c%0d: got %b expected 0", k, in_ready); end
            n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mul_valid_c%0d: got %b expected 0", k, out_valid); end
        end
        @(posedge clk);
        #1;
        n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL mul_valid_done: got %b expected 1", out_valid); end
        n_checks++; if (out !== 9'h0E1) begin n_fail++; $display("FAIL mul_out: got %h expected %h", out, 9'h0E1); end
        n_checks++; if (carry !== 1'b0) begin n_fail++; $display("FAIL mul_carry: got %b expected 0", carry); end
        n_checks++; if (zero !== 1'b0) begin n_fail++; $display("FAIL mul_zero: got %b expected 0", zero); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL mul_ready_done: got %b expected 1", in_ready); end
    endtask

    task automatic test_rotate;
        issue(4'b1001, 4'd5, 3'd5);
        n_checks++; if (out !== 9'h003) begin n_fail++; $display("FAIL rol_by5: got %h expected %h", out, 9'h003); end
        n_checks++; if (carry !== 1'b0) begin n_fail++; $display("FAIL rol_carry: got %b expected 0", carry); end
        issue(4'b1001, 4'd5, 3'd6);
        n_checks++; if (out !== 9'h00C) begin n_fail++; $display("FAIL ror_by5: got %h expected %h", out, 9'h00C); end
        issue(4'b1001, 4'd4, 3'd5);
        n_checks++; if (out !== 9'h009) begin n_fail++; $display("FAIL rol_by4: got %h expected %h", out, 9'h009); end
        issue(4'b1001, 4'd0, 3'd6);
        n_checks++; if (out !== 9'h009) begin n_fail++; $display("FAIL ror_by0: got %h expected %h", out, 9'h009); end
    endtask

    task automatic test_back_to_back;
        issue(4'hA, 4'h5, 3'd3);
        out_ready = 1'b0;
        n_checks++; if (out !== 9'h00F) begin n_fail++; $display("FAIL xor_out: got %h expected %h", out, 9'h00F); end
        n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL xor_valid: got %b expected 1", out_valid); end
        @(negedge clk);
        in1 = 4'd1; in2 = 4'd2; op = 3'd0; in_valid = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            @(posedge clk);
            #1;
            n_checks++; if (out !== 9'h00F) begin n_fail++; $display("FAIL stall_out_c%0d: got %h expected %h", k, out, 9'h00F); end
            n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL stall_valid_c%0d: got %b expected 1", k, out_valid); end
            n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL stall_ready_c%0d: got %b expected 0", k, in_ready); end
        end
        @(negedge clk);
        out_ready = 1'b1;
        in1 = 4'h3; in2 = 4'h4; op = 3'd4; in_valid = 1'b1;
        #1;
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready: got %b expected 1", in_ready); end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        n_checks++; if (out !== 9'h007) begin n_fail++; $display("FAIL b2b_or_out: got %h expected %h", out, 9'h007); end
        n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_or_valid: got %b expected 1", out_valid); end
        @(posedge clk);
        #1;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_drain: got %b expected 0", out_valid); end
    endtask

    task automatic test_reset_mid_mul;
        issue(4'd7, 4'd9, 3'd7);
        @(posedge clk);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        n_checks++; if (out !== 9'h000) begin n_fail++; $display("FAIL abort_out: got %h expected %h", out, 9'h000); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL abort_valid: got %b expected 0", out_valid); end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL abort_ready: got %b expected 1", in_ready); end
        for (int k = 1; k <= 6; k++) begin
            @(posedge clk);
            #1;
            n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL abort_stale_c%0d: got %b expected 0", k, out_valid); end
        end
        issue(4'd7, 4'd9, 3'd7);
        for (int k = 2; k <= 4; k++) begin
            @(posedge clk);
            #1;
            n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL remul_valid_c%0d: got %b expected 0", k, out_valid); end
        end
        @(posedge clk);
        #1;
        n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL remul_valid_done: got %b expected 1", out_valid); end
        n_checks++; if (out !== 9'h03F) begin n_fail++; $display("FAIL remul_out: got %h expected %h", out, 9'h03F); end
    endtask

    initial begin
        rst_n     = 1'b0;
        in1       = '0;
        in2       = '0;
        op        = '0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        test_reset;
        test_add;
        test_sub;
        test_mul;
        test_rotate;
        test_back_to_back;
        test_reset_mid_mul;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
